checker_scheduler: RTL and testbench

Sequencing controller for the recognition back end: on a start pulse from the neural layer it snapshots the 20 output-neuron values and scans them serially with one shared 32-bit comparator. It then commits a thresholded one-hot class decision with a done handshake. It sits between the neural output layer and the LED decode / encode consumers, replacing the free-running parallel compare.

---
 rtl/checker_scheduler_if.sv | 24 ++
 rtl/checker_scheduler.sv | 125 ++++++++++++
 tb/tb_checker_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/checker_scheduler_if.sv
// rtl/checker_scheduler_if.sv - start/snapshot request and decision result bundle for checker_scheduler
interface checker_scheduler_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 20
);
    logic                              start;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] neural_outputs;
    logic                              busy;
    logic                              done;
    logic [NUM_CLASSES-1:0]            encode;
    logic [4:0]                        class_idx;
    logic                              reject;
    logic                              overrun;

    modport master (
        output start, neural_outputs,
        input  busy, done, encode, class_idx, reject, overrun
    );

    modport slave (
        input  start, neural_outputs,
        output busy, done, encode, class_idx, reject, overrun
    );
endinterface

// File: rtl/checker_scheduler.sv
// rtl/checker_scheduler.sv - serial argmax/threshold class decision over a neuron snapshot
// Optional decision hysteresis: CHECKER_SCHED_HYST_EN
module checker_scheduler #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_CLASSES = 20,
    parameter logic [DATA_WIDTH-1:0] THRESHOLD   = 32'h0000_8000
) (
    input  logic               clk,
    input  logic               rst_n,
    checker_scheduler_if.slave sched_if
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN, S_DECIDE} state_t;

    localparam logic [4:0]             LAST_IDX = 5'(NUM_CLASSES - 1);
    localparam logic [4:0]             NO_CLASS = 5'h1F;
    localparam logic [NUM_CLASSES-1:0] ONE_HOT0 = NUM_CLASSES'(1);

    state_t                            state_q, state_d;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] snap_q;
    logic [DATA_WIDTH-1:0]             best_val_q;
    logic [4:0]                        best_idx_q;
    logic [4:0]                        idx_q;
    logic                              busy_q;
    logic                              done_q;
    logic [NUM_CLASSES-1:0]            encode_q;
    logic [4:0]                        class_idx_q;
    logic                              reject_q;
    logic                              overrun_q;

    logic [DATA_WIDTH-1:0]             scan_val;
    logic                              dec_reject;
    logic [4:0]                        dec_idx;
    logic [NUM_CLASSES-1:0]            dec_encode;
    logic                              commit;

`ifdef CHECKER_SCHED_HYST_EN
    logic [4:0]                        raw_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (sched_if.start) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SCAN;
            S_SCAN:    if (idx_q == LAST_IDX) state_d = S_DECIDE;
            S_DECIDE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scan_val   = snap_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        dec_reject = (best_val_q < THRESHOLD);
        dec_idx    = dec_reject ? NO_CLASS : best_idx_q;
        dec_encode = dec_reject ? '0 : (ONE_HOT0 << best_idx_q);
`ifdef CHECKER_SCHED_HYST_EN
        // Only a result seen twice in a row reaches the consumers.
        commit     = (dec_idx == raw_q);
`else
        commit     = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q      <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            encode_q    <= '0;
            class_idx_q <= NO_CLASS;
            reject_q    <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CHECKER_SCHED_HYST_EN
            raw_q       <= 5'h1E;
`endif
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= 1'b0;
            if (sched_if.start && (state_q != S_IDLE)) overrun_q <= 1'b1;
            case (state_q)
                S_CAPTURE: begin
                    snap_q     <= sched_if.neural_outputs;
                    best_val_q <= sched_if.neural_outputs[DATA_WIDTH-1:0];
                    best_idx_q <= '0;
                    idx_q      <= 5'd1;
                end
                S_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (scan_val > best_val_q) begin
                        best_val_q <= scan_val;
                        best_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + 5'd1;
                end
                S_DECIDE: begin
                    done_q <= 1'b1;
                    if (commit) begin
                        encode_q    <= dec_encode;
                        class_idx_q <= dec_idx;
                        reject_q    <= dec_reject;
                    end
`ifdef CHECKER_SCHED_HYST_EN
                    raw_q <= dec_idx;
`endif
                end
                default: ;
            endcase
        end
    end

    assign sched_if.busy      = busy_q;
    assign sched_if.done      = done_q;
    assign sched_if.encode    = encode_q;
    assign sched_if.class_idx = class_idx_q;
    assign sched_if.reject    = reject_q;
    assign sched_if.overrun   = overrun_q;
endmodule

// File: tb/tb_checker_scheduler.sv
// tb/tb_checker_scheduler.sv - self-checking bench for checker_scheduler with argmax/threshold reference model
module tb_checker_scheduler;
    localparam int          DW = 32;
    localparam int          NC = 20;
    localparam logic [31:0] TH = 32'h0000_8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    checker_scheduler_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) bus ();

    checker_scheduler #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .THRESHOLD(TH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0]   vals [NC];
    logic [4:0]    m_idx  = 5'h1F;
    logic          m_rej  = 1'b0;
    logic [NC-1:0] m_enc  = '0;
    logic [4:0]    m_hist = 5'h1E;

    function automatic void model_reset();
        m_idx  = 5'h1F;
        m_rej  = 1'b0;
        m_enc  = '0;
        m_hist = 5'h1E;
    endfunction

    // Winner = lowest index holding the maximum; rejected below threshold.
    function automatic void model_decide(input logic [31:0] v [NC]);
        logic [31:0] mx;
        int          best;
        logic [4:0]  raw;
        logic        cm;
        mx = 0;
        for (int k = 0; k < NC; k++) if (v[k] > mx) mx = v[k];
        best = 0;
        for (int k = NC - 1; k >= 0; k--) if (v[k] == mx) best = k;
        raw = (mx < TH) ? 5'h1F : 5'(best);
`ifdef CHECKER_SCHED_HYST_EN
        cm = (raw == m_hist);
        m_hist = raw;
`else
        cm = 1'b1;
`endif
        if (cm) begin
            m_idx = raw;
            m_rej = (raw == 5'h1F);
            m_enc = m_rej ? '0 : (NC'(1) << best);
        end
    endfunction

    task automatic drive_vals();
        for (int k = 0; k < NC; k++) bus.neural_outputs[k*DW +: DW] = vals[k];
    endtask

    task automatic fill_low(input logic [31:0] hi);
        for (int k = 0; k < NC; k++) vals[k] = $urandom_range(0, hi);
    endtask

    task automatic run_decision(output int lat, output logic busy1);
        drive_vals();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy1 = bus.busy;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.neural_outputs = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", bus.done); end
        checks++; if (bus.encode !== '0) begin errors++; $display("FAIL reset_encode got=%h want=0", bus.encode); end
        checks++; if (bus.class_idx !== 5'h1F) begin errors++; $display("FAIL reset_class_idx got=%h want=1f", bus.class_idx); end
        checks++; if (bus.reject !== 1'b0) begin errors++; $display("FAIL reset_reject got=%0b want=0", bus.reject); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b want=0", bus.overrun); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_winner();
        int   lat;
        logic b1;
        for (int k = 0; k < NC; k++) vals[k] = 32'h0000_0100;
        vals[7] = 32'h0001_0000;
        run_decision(lat, b1);
        model_decide(vals);
        checks++; if (lat !== 21) begin errors++; $display("FAIL single_latency got=%0d want=21", lat); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL single_busy_rise got=%0b want=1", b1); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%0b want=0", bus.busy); end
        checks++; if (bus.encode !== m_enc) begin errors++; $display("FAIL single_encode got=%h want=%h", bus.encode, m_enc); end
        checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL single_class_idx got=%h want=%h", bus.class_idx, m_idx); end
        checks++; if (bus.reject !== m_rej) begin errors++; $display("FAIL single_reject got=%0b want=%0b", bus.reject, m_rej); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%0b want=0", bus.done); end
        checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL single_hold got=%h want=%h", bus.class_idx, m_idx); end
    endtask

    task automatic test_tie_threshold();
        int   lat;
        logic b1;
        logic [31:0] peak [2];
        peak[0] = 32'h0000_8000;
        peak[1] = 32'h0000_7FFF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NC; k++) vals[k] = '0;
            vals[3]  = peak[r];
            vals[12] = peak[r];
            run_decision(lat, b1);
            model_decide(vals);
            checks++; if (lat !== 21) begin errors++; $display("FAIL tie%0d_latency got=%0d want=21", r, lat); end
            checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL tie%0d_class_idx got=%h want=%h", r, bus.class_idx, m_idx); end
            checks++; if (bus.reject !== m_rej) begin errors++; $display("FAIL tie%0d_reject got=%0b want=%0b", r, bus.reject, m_rej); end
            checks++; if (bus.encode !== m_enc) begin errors++; $display("FAIL tie%0d_encode got=%h want=%h", r, bus.encode, m_enc); end
        end
    endtask

    task automatic test_isolation_overrun();
        int ndone;
        int first;
        logic [4:0] idx_at;
        ndone = 0;
        first = -1;
        idx_at = 5'h00;
        fill_low(32'h0000_0FFF);
        vals[5] = 32'h0002_0000;
        model_decide(vals);
        drive_vals();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first < 0) first = c;
                idx_at = bus.class_idx;
            end
            if (c == 3) begin
                fill_low(32'h0000_0FFF);
                vals[9] = 32'h0004_0000;
                drive_vals();
                bus.start = 1'b1;
            end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL iso_done_count got=%0d want=1", ndone); end
        checks++; if (first !== 21) begin errors++; $display("FAIL iso_latency got=%0d want=21", first); end
        checks++; if (idx_at !== m_idx) begin errors++; $display("FAIL iso_class_idx got=%h want=%h", idx_at, m_idx); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL iso_overrun got=%0b want=1", bus.overrun); end
    endtask

    task automatic test_reset_mid_scan();
        int   lat;
        int   ndone;
        logic b1;
        fill_low(32'h0000_FFFF);
        vals[2] = 32'h0010_0000;
        drive_vals();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_scan_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_scan_overrun got=%0b want=0", bus.overrun); end
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_scan_stray_done got=%0d want=0", ndone); end
        fill_low(32'h0000_FFFF);
        vals[19] = 32'h0004_0000;
        run_decision(lat, b1);
        model_decide(vals);
        checks++; if (lat !== 21) begin errors++; $display("FAIL rst_scan_latency got=%0d want=21", lat); end
        checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL rst_scan_class_idx got=%h want=%h", bus.class_idx, m_idx); end
    endtask

    task automatic test_random();
        int   lat;
        int   a;
        int   b;
        logic b1;
        logic [31:0] v;
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: fill_low(32'h0000_7FFF);
                1: for (int k = 0; k < NC; k++) vals[k] = $urandom();
                2: begin
                    fill_low(32'h0000_7FFF);
                    v = $urandom_range(32'h0000_8000, 32'h0000_FFFF);
                    a = $urandom_range(0, NC - 1);
                    b = $urandom_range(0, NC - 1);
                    vals[a] = v;
                    vals[b] = v;
                end
                default: begin
                    fill_low(32'h0000_7FFF);
                    a = $urandom_range(0, NC - 1);
                    vals[a] = TH;
                end
            endcase
            run_decision(lat, b1);
            model_decide(vals);
            checks++; if (lat !== 21) begin errors++; $display("FAIL rand%0d_latency got=%0d want=21", it, lat); end
            checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL rand%0d_class_idx got=%h want=%h", it, bus.class_idx, m_idx); end
            checks++; if (bus.encode !== m_enc) begin errors++; $display("FAIL rand%0d_encode got=%h want=%h", it, bus.encode, m_enc); end
            checks++; if (bus.reject !== m_rej) begin errors++; $display("FAIL rand%0d_reject got=%0b want=%0b", it, bus.reject, m_rej); end
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic b1;
        for (int r = 0; r < 3; r++) begin
            fill_low(32'h000F_FFFF);
            run_decision(lat, b1);
            model_decide(vals);
            checks++; if (lat !== 21) begin errors++; $display("FAIL b2b%0d_latency got=%0d want=21", r, lat); end
            checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL b2b%0d_class_idx got=%h want=%h", r, bus.class_idx, m_idx); end
        end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%0b want=0", bus.overrun); end
    endtask

    task automatic test_hysteresis();
        int   lat;
        int   ndone;
        logic b1;
        int   win [4];
        win[0] = 4; win[1] = 4; win[2] = 6; win[3] = 6;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        ndone = 0;
        for (int r = 0; r < 4; r++) begin
            fill_low(32'h0000_0FFF);
            vals[win[r]] = 32'h0003_0000;
            run_decision(lat, b1);
            model_decide(vals);
            if (lat > 0) ndone++;
            checks++; if (bus.class_idx !== m_idx) begin errors++; $display("FAIL hyst%0d_class_idx got=%h want=%h", r, bus.class_idx, m_idx); end
            checks++; if (bus.encode !== m_enc) begin errors++; $display("FAIL hyst%0d_encode got=%h want=%h", r, bus.encode, m_enc); end
        end
        checks++; if (ndone !== 4) begin errors++; $display("FAIL hyst_done_count got=%0d want=4", ndone); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.neural_outputs = '0;
        test_reset();
        test_single_winner();
        test_tie_threshold();
        test_isolation_overrun();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        test_hysteresis();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
